bus_arbiter_2x1: RTL and testbench

//  Shares one bus_if-style slave port between two masters: m0 (instruction fetch) and m1 (data load/store).

---
 rtl/bus_arbiter_2x1.sv | 145 ++++++++++++++
 tb/tb_bus_arbiter_2x1.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_2x1.sv
// Two-master to one-slave bus arbiter: fetch (m0) and data (m1) share one slave port.
// Grant is held until the slave completes, the master abandons, or the watchdog fault-completes.
module bus_arbiter_2x1 #(
   parameter bit          FIXED_PRIO     = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] FAULT_DATA     = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_write_data,
   input  logic [3:0]  m0_wstrb,
   input  logic        m0_instr,
   output logic        m0_ready,
   output logic [31:0] m0_read_data,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_write_data,
   input  logic [3:0]  m1_wstrb,
   input  logic        m1_instr,
   output logic        m1_ready,
   output logic [31:0] m1_read_data,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [31:0] s_write_data,
   output logic [3:0]  s_wstrb,
   output logic        s_instr,
   input  logic        s_ready,
   input  logic [31:0] s_read_data,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_GRANT0 = 2'd1;
   localparam logic [1:0] ST_GRANT1 = 2'd2;

   localparam bit         WDOG_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [8:0] WDOG_LAST = 9'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic        last_served_r;      // 1'b1 = m1 served last
   logic        last_served_nxt_s;
   logic [8:0]  wdog_r;
   logic [8:0]  wdog_nxt_s;
   logic        gnt0_s;
   logic        gnt1_s;
   logic        gnt_valid_s;
   logic        timeout_hit_s;
   logic [31:0] resp_data_s;

   assign gnt0_s        = (state_r == ST_GRANT0);
   assign gnt1_s        = (state_r == ST_GRANT1);
   assign gnt_valid_s   = (gnt0_s & m0_valid) | (gnt1_s & m1_valid);
   // A slave response in the last watchdog cycle takes precedence over the fault.
   assign timeout_hit_s = WDOG_EN & gnt_valid_s & ~s_ready & (wdog_r == WDOG_LAST);
   assign resp_data_s   = timeout_hit_s ? FAULT_DATA : s_read_data;

   // Request path: forward the granted master's request to the slave.
   always_comb begin
      s_addr       = 32'h0;
      s_write_data = 32'h0;
      s_wstrb      = 4'h0;
      s_instr      = 1'b0;
      if (gnt0_s) begin
         s_addr       = m0_addr;
         s_write_data = m0_write_data;
         s_wstrb      = m0_wstrb;
         s_instr      = m0_instr;
      end else if (gnt1_s) begin
         s_addr       = m1_addr;
         s_write_data = m1_write_data;
         s_wstrb      = m1_wstrb;
         s_instr      = m1_instr;
      end else begin
         s_addr       = 32'h0;
         s_write_data = 32'h0;
         s_wstrb      = 4'h0;
         s_instr      = 1'b0;
      end
   end

   assign s_valid      = gnt_valid_s & ~timeout_hit_s;
   assign m0_ready     = gnt0_s & (s_ready | timeout_hit_s);
   assign m1_ready     = gnt1_s & (s_ready | timeout_hit_s);
   assign m0_read_data = gnt0_s ? resp_data_s : 32'h0;
   assign m1_read_data = gnt1_s ? resp_data_s : 32'h0;
   assign grant_o      = {gnt1_s, gnt0_s};
   assign timeout_o    = timeout_hit_s;

   // Arbitration, completion/abandon handling and watchdog next-state logic.
   always_comb begin
      state_nxt_s       = state_r;
      last_served_nxt_s = last_served_r;
      wdog_nxt_s        = wdog_r;
      case (state_r)
         ST_IDLE: begin
            wdog_nxt_s = 9'd0;
            if (m0_valid && m1_valid) begin
               if (FIXED_PRIO || last_served_r) begin
                  state_nxt_s = ST_GRANT0;
               end else begin
                  state_nxt_s = ST_GRANT1;
               end
            end else if (m0_valid) begin
               state_nxt_s = ST_GRANT0;
            end else if (m1_valid) begin
               state_nxt_s = ST_GRANT1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_GRANT0, ST_GRANT1: begin
            if (!gnt_valid_s) begin
               state_nxt_s = ST_IDLE;
            end else if (s_ready || timeout_hit_s) begin
               state_nxt_s       = ST_IDLE;
               last_served_nxt_s = gnt1_s;
            end else begin
               wdog_nxt_s = wdog_r + 9'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            wdog_nxt_s  = 9'd0;
         end
      endcase
   end

   // State registers; reset leaves m1 as last served so m0 wins the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r       <= ST_IDLE;
         last_served_r <= 1'b1;
         wdog_r        <= 9'd0;
      end else begin
         state_r       <= state_nxt_s;
         last_served_r <= last_served_nxt_s;
         wdog_r        <= wdog_nxt_s;
      end
   end

endmodule

// File: tb/tb_bus_arbiter_2x1.sv
// Scoreboard bench for bus_arbiter_2x1: round-robin instance (a) and fixed-priority instance (b).
module tb_bus_arbiter_2x1;

   typedef struct packed {
      logic [1:0]  who;
      logic [31:0] data;
      logic        to;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n_a, rst_n_b;
   logic        m0_valid, m0_instr, m1_valid, m1_instr;
   logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        s_ready, s_ready_b, use_echo;
   logic [31:0] rd_val;
   logic [31:0] slave_rd;

   logic        m0_ready_a, m1_ready_a, s_valid_a, s_instr_a, timeout_a;
   logic [31:0] m0_rd_a, m1_rd_a, s_addr_a, s_wd_a;
   logic [3:0]  s_wstrb_a;
   logic [1:0]  grant_a;
   logic        m0_ready_b, m1_ready_b, s_valid_b, s_instr_b, timeout_b;
   logic [31:0] m0_rd_b, m1_rd_b, s_addr_b, s_wd_b;
   logic [3:0]  s_wstrb_b;
   logic [1:0]  grant_b;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_done   = 0;

   always #5 clk = ~clk;

   assign slave_rd = use_echo ? {s_addr_a[15:0], 16'h5A5A} : rd_val;

   bus_arbiter_2x1 #(.FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(8), .FAULT_DATA(32'hDEAD_BEEF)) dut_a (
      .clk_i(clk), .rst_ni(rst_n_a),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_write_data(m0_wd), .m0_wstrb(m0_wstrb),
      .m0_instr(m0_instr), .m0_ready(m0_ready_a), .m0_read_data(m0_rd_a),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_write_data(m1_wd), .m1_wstrb(m1_wstrb),
      .m1_instr(m1_instr), .m1_ready(m1_ready_a), .m1_read_data(m1_rd_a),
      .s_valid(s_valid_a), .s_addr(s_addr_a), .s_write_data(s_wd_a), .s_wstrb(s_wstrb_a),
      .s_instr(s_instr_a), .s_ready(s_ready), .s_read_data(slave_rd),
      .grant_o(grant_a), .timeout_o(timeout_a)
   );

   bus_arbiter_2x1 #(.FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(8), .FAULT_DATA(32'hDEAD_BEEF)) dut_b (
      .clk_i(clk), .rst_ni(rst_n_b),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_write_data(m0_wd), .m0_wstrb(m0_wstrb),
      .m0_instr(m0_instr), .m0_ready(m0_ready_b), .m0_read_data(m0_rd_b),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_write_data(m1_wd), .m1_wstrb(m1_wstrb),
      .m1_instr(m1_instr), .m1_ready(m1_ready_b), .m1_read_data(m1_rd_b),
      .s_valid(s_valid_b), .s_addr(s_addr_b), .s_write_data(s_wd_b), .s_wstrb(s_wstrb_b),
      .s_instr(s_instr_b), .s_ready(s_ready_b), .s_read_data(slave_rd),
      .grant_o(grant_b), .timeout_o(timeout_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] who, input logic [31:0] data, input logic to);
      exp_t e;
      e.who  = who;
      e.data = data;
      e.to   = to;
      sb_q.push_back(e);
   endtask

   task automatic wait_done(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (n_done >= target) return;
         tick();
      end
      check_eq("wait_done_budget", 32'(n_done), 32'(target));
   endtask

   // Completion monitor for instance a: every ready pulse pops one expected response.
   always @(negedge clk) begin
      exp_t e;
      if (m0_ready_a || m1_ready_a) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_ready", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            check_eq("sb_master", 32'({m1_ready_a, m0_ready_a}), 32'(e.who));
            check_eq("sb_data", m0_ready_a ? m0_rd_a : m1_rd_a, e.data);
            check_eq("sb_other_data", m0_ready_a ? m1_rd_a : m0_rd_a, 32'h0);
            check_eq("sb_timeout", 32'(timeout_a), 32'(e.to));
            n_done++;
         end
      end
   end

   initial begin
      int gcnt, seen, c0, c1, g1;
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      m0_valid = 1'b1; m0_addr = 32'h0000_0ABC; m0_wd = 32'h0; m0_wstrb = 4'h0; m0_instr = 1'b1;
      m1_valid = 1'b0; m1_addr = 32'h0; m1_wd = 32'h0; m1_wstrb = 4'h0; m1_instr = 1'b0;
      s_ready = 1'b1; s_ready_b = 1'b0; use_echo = 1'b0; rd_val = 32'h1111_2222;

      // reset values while inputs are active
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_s_valid", 32'(s_valid_a), 32'h0);
      check_eq("rst_s_addr", s_addr_a, 32'h0);
      check_eq("rst_grant", 32'(grant_a), 32'h0);
      check_eq("rst_m0_ready", 32'(m0_ready_a), 32'h0);
      check_eq("rst_m0_rd", m0_rd_a, 32'h0);
      check_eq("rst_timeout", 32'(timeout_a), 32'h0);
      m0_valid = 1'b0; s_ready = 1'b0; rd_val = 32'h0;
      @(posedge clk); #1 rst_n_a = 1'b1;

      // round-robin with both masters held, slave answering in the first grant cycle
      tick();
      m0_valid = 1'b1; m0_addr = 32'h0000_1000; m0_instr = 1'b1;
      m1_valid = 1'b1; m1_addr = 32'h0000_2000; m1_instr = 1'b0;
      use_echo = 1'b1; s_ready = 1'b1;
      push_exp(2'b01, 32'h1000_5A5A, 1'b0);
      push_exp(2'b10, 32'h2000_5A5A, 1'b0);
      push_exp(2'b01, 32'h1000_5A5A, 1'b0);
      push_exp(2'b10, 32'h2000_5A5A, 1'b0);
      wait_done(4, 40);
      m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; use_echo = 1'b0;
      @(negedge clk);
      check_eq("rr_idle_grant", 32'(grant_a), 32'h0);

      // single m0 read with two-cycle slave latency
      tick();
      m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0; m0_instr = 1'b1;
      push_exp(2'b01, 32'hCAFE_0001, 1'b0);
      @(negedge clk);
      check_eq("rd_c0_s_valid", 32'(s_valid_a), 32'h0);
      check_eq("rd_c0_grant", 32'(grant_a), 32'h0);
      tick(); @(negedge clk);
      check_eq("rd_c1_s_valid", 32'(s_valid_a), 32'h1);
      check_eq("rd_c1_s_addr", s_addr_a, 32'h0000_0100);
      check_eq("rd_c1_s_instr", 32'(s_instr_a), 32'h1);
      check_eq("rd_c1_grant", 32'(grant_a), 32'h1);
      tick(); @(negedge clk);
      check_eq("rd_c2_m0_ready", 32'(m0_ready_a), 32'h0);
      tick();
      s_ready = 1'b1; rd_val = 32'hCAFE_0001;
      @(negedge clk);
      check_eq("rd_c3_grant", 32'(grant_a), 32'h1);
      check_eq("rd_c3_m0_ready", 32'(m0_ready_a), 32'h1);
      tick();
      m0_valid = 1'b0; s_ready = 1'b0; rd_val = 32'h0;
      @(negedge clk);
      check_eq("rd_c4_grant", 32'(grant_a), 32'h0);

      // m1 partial write
      tick();
      m1_valid = 1'b1; m1_addr = 32'h0000_2000; m1_wd = 32'h1234_5678; m1_wstrb = 4'b0011;
      push_exp(2'b10, 32'h0, 1'b0);
      tick(); @(negedge clk);
      check_eq("wr_s_addr", s_addr_a, 32'h0000_2000);
      check_eq("wr_s_wdata", s_wd_a, 32'h1234_5678);
      check_eq("wr_s_wstrb", 32'(s_wstrb_a), 32'h3);
      check_eq("wr_grant", 32'(grant_a), 32'h2);
      check_eq("wr_m0_ready_c1", 32'(m0_ready_a), 32'h0);
      tick();
      s_ready = 1'b1;
      @(negedge clk);
      check_eq("wr_m0_ready_c2", 32'(m0_ready_a), 32'h0);
      tick();
      m1_valid = 1'b0; m1_wd = 32'h0; m1_wstrb = 4'h0; s_ready = 1'b0;

      // watchdog fault completion with a silent slave
      tick();
      m0_valid = 1'b1; m0_addr = 32'h0000_0300;
      push_exp(2'b01, 32'hDEAD_BEEF, 1'b1);
      gcnt = 0; seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (grant_a == 2'b01) gcnt++;
         if (m0_ready_a) begin
            seen = 1;
            check_eq("to_s_valid", 32'(s_valid_a), 32'h0);
            check_eq("to_grant_cycles", 32'(gcnt), 32'd8);
         end else begin
            tick();
         end
      end
      check_eq("to_seen", 32'(seen), 32'h1);
      tick();
      m0_valid = 1'b0;
      @(negedge clk);
      check_eq("to_idle_grant", 32'(grant_a), 32'h0);

      // slave answers exactly in the last watchdog cycle: the answer wins
      tick();
      m0_valid = 1'b1; m0_addr = 32'h0000_0304;
      push_exp(2'b01, 32'h0BAD_F00D, 1'b0);
      repeat (8) tick();
      s_ready = 1'b1; rd_val = 32'h0BAD_F00D;
      @(negedge clk);
      check_eq("race_timeout", 32'(timeout_a), 32'h0);
      check_eq("race_m0_ready", 32'(m0_ready_a), 32'h1);
      tick();
      m0_valid = 1'b0; s_ready = 1'b0; rd_val = 32'h0;

      // m1 abandons its grant while m0 waits
      tick();
      m1_valid = 1'b1; m1_addr = 32'h0000_0400;
      tick();
      m0_valid = 1'b1; m0_addr = 32'h0000_0500;
      tick();
      tick();
      m1_valid = 1'b0;
      @(negedge clk);
      check_eq("ab_s_valid", 32'(s_valid_a), 32'h0);
      check_eq("ab_m1_ready", 32'(m1_ready_a), 32'h0);
      tick(); @(negedge clk);
      check_eq("ab_idle_grant", 32'(grant_a), 32'h0);
      tick();
      push_exp(2'b01, 32'h55AA_0005, 1'b0);
      s_ready = 1'b1; rd_val = 32'h55AA_0005;
      @(negedge clk);
      check_eq("ab_m0_grant", 32'(grant_a), 32'h1);
      check_eq("ab_m0_addr", s_addr_a, 32'h0000_0500);
      tick();
      m0_valid = 1'b0; s_ready = 1'b0; rd_val = 32'h0;

      // asynchronous reset in the middle of a GRANT1 transfer
      tick();
      m1_valid = 1'b1; m1_addr = 32'h0000_0600; m1_wstrb = 4'hF; m1_instr = 1'b1;
      tick();
      m0_valid = 1'b1; m0_addr = 32'h0000_0700;
      #2;
      rd_val = 32'h7777_7777; s_ready = 1'b1; rst_n_a = 1'b0;
      #1;
      check_eq("ar_s_valid", 32'(s_valid_a), 32'h0);
      check_eq("ar_grant", 32'(grant_a), 32'h0);
      check_eq("ar_m1_ready", 32'(m1_ready_a), 32'h0);
      check_eq("ar_m1_rd", m1_rd_a, 32'h0);
      check_eq("ar_s_addr", s_addr_a, 32'h0);
      check_eq("ar_s_wstrb", 32'(s_wstrb_a), 32'h0);
      s_ready = 1'b0;
      @(posedge clk); #1 rst_n_a = 1'b1;
      @(negedge clk);
      check_eq("ar_rel_idle", 32'(grant_a), 32'h0);
      tick();
      push_exp(2'b01, 32'h7777_7777, 1'b0);
      s_ready = 1'b1;
      @(negedge clk);
      check_eq("ar_first_grant", 32'(grant_a), 32'h1);
      tick();
      m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; rd_val = 32'h0;
      m1_wstrb = 4'h0; m1_instr = 1'b0;

      // fixed priority: m0 always wins, m1 starves
      tick();
      rst_n_a = 1'b0; rst_n_b = 1'b1;
      tick();
      m0_valid = 1'b1; m1_valid = 1'b1; s_ready_b = 1'b1;
      c0 = 0; c1 = 0; g1 = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (m0_ready_b) c0++;
         if (m1_ready_b) c1++;
         if (grant_b == 2'b10) g1++;
      end
      check_eq("fp_m0_served", 32'(c0), 32'd8);
      check_eq("fp_m1_served", 32'(c1), 32'd0);
      check_eq("fp_m1_grants", 32'(g1), 32'd0);
      m0_valid = 1'b0; m1_valid = 1'b0; s_ready_b = 1'b0;

      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      check_eq("sb_done", 32'(n_done), 32'd10);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
